// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Multiplexed 7-segment display driver. The slow square wave from the
// frequency divider is used as a scan tick. Each rising tick edge (detected
// in the clk domain) advances a dwell counter. After DWELL ticks the scanner
// moves to the next digit. Between digits there is always one clk with every
// anode off, so the previous digit's segment pattern cannot ghost onto the
// next one. All digit values are captured into a shadow register once per
// frame (when o_frame pulses). A change to i_value in mid-frame therefore
// cannot tear the display.
//
// Handshake / timing: there is no valid/ready pair. i_tick is treated purely
// as a level. adv = i_tick & ~tick_d is high for exactly one clk per tick
// period. i_en low forces IDLE on the next clk and wins over adv.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active-high
//   i_tick   in   divided clock (scan tick), used as a level
//   i_en     in   display enable
//   i_value  in   4*N_DIGITS hex nibbles, digit 0 = bits [3:0] (rightmost)
//   i_dp     in   N_DIGITS decimal-point requests
//   o_seg    out  segments {g,f,e,d,c,b,a}
//   o_dp     out  decimal point of the active digit
//   o_an     out  one-hot digit enable
//   o_frame  out  one-clk pulse when a new frame snapshot is taken
//
// Optional feature (macro SEVEN_SEG_LEADING_ZERO_BLANK_EN):
//   When this macro is defined, digits above the most significant non-zero
//   nibble of the shadow value show every segment off. The anode still
//   scans, and the decimal point still follows the shadow. Digit 0 is always
//   shown.
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
   parameter int N_DIGITS       = 4,
   parameter int DWELL          = 1,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_tick,
   input  logic                  i_en,
   input  logic [4*N_DIGITS-1:0] i_value,
   input  logic [N_DIGITS-1:0]   i_dp,
   output logic [6:0]            o_seg,
   output logic                  o_dp,
   output logic [N_DIGITS-1:0]   o_an,
   output logic                  o_frame
);

   localparam int DIW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CW  = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [DIW-1:0]      LAST_DIGIT = DIW'(N_DIGITS - 1);
   localparam logic [CW-1:0]       LAST_DWELL = CW'(DWELL - 1);
   localparam logic                SEG_INV    = (SEG_ACTIVE_LOW != 0);
   localparam logic                AN_INV     = (AN_ACTIVE_LOW != 0);
   localparam logic [6:0]          SEG_OFF    = {7{SEG_INV}};
   localparam logic [N_DIGITS-1:0] AN_OFF     = {N_DIGITS{AN_INV}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [DIW-1:0]        digit, digit_nxt;
   logic [CW-1:0]         dwell, dwell_nxt;
   logic                  tick_d;
   logic                  adv;
   logic                  snap;
   logic [4*N_DIGITS-1:0] shadow_value, shadow_value_nxt;
   logic [N_DIGITS-1:0]   shadow_dp, shadow_dp_nxt;
   logic [N_DIGITS-1:0]   keep;

   logic [6:0]            seg_nxt;
   logic                  dp_nxt;
   logic [N_DIGITS-1:0]   an_nxt;
   logic [N_DIGITS-1:0]   an_hot;
   logic [3:0]            nibble;
   logic [6:0]            seg_hi;

   assign adv = i_tick & ~tick_d;

   // Active-high segment pattern {g,f,e,d,c,b,a}.
   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b0111111;
         4'h1:    s = 7'b0000110;
         4'h2:    s = 7'b1011011;
         4'h3:    s = 7'b1001111;
         4'h4:    s = 7'b1100110;
         4'h5:    s = 7'b1101101;
         4'h6:    s = 7'b1111101;
         4'h7:    s = 7'b0000111;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1101111;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b1111100;
         4'hC:    s = 7'b0111001;
         4'hD:    s = 7'b1011110;
         4'hE:    s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // -------------------------------------------------------------------------
   // State register. The outputs are registered alongside the state, so they
   // are computed from the next-state values.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         digit        <= '0;
         dwell        <= '0;
         tick_d       <= 1'b0;
         shadow_value <= '0;
         shadow_dp    <= '0;
         o_seg        <= SEG_OFF;
         o_dp         <= SEG_INV;
         o_an         <= AN_OFF;
         o_frame      <= 1'b0;
      end else begin
         state        <= state_nxt;
         digit        <= digit_nxt;
         dwell        <= dwell_nxt;
         tick_d       <= i_tick;
         shadow_value <= shadow_value_nxt;
         shadow_dp    <= shadow_dp_nxt;
         o_seg        <= seg_nxt;
         o_dp         <= dp_nxt;
         o_an         <= an_nxt;
         o_frame      <= snap;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      digit_nxt = digit;
      dwell_nxt = dwell;
      snap      = 1'b0;
      if (!i_en) begin
         state_nxt = IDLE;
         digit_nxt = '0;
         dwell_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (adv) begin
                  snap      = 1'b1;
                  state_nxt = BLANK;
                  digit_nxt = '0;
                  dwell_nxt = '0;
               end
            end
            BLANK: state_nxt = SHOW;
            SHOW: begin
               if (adv) begin
                  if (dwell == LAST_DWELL) begin
                     dwell_nxt = '0;
                     state_nxt = BLANK;
                     if (digit == LAST_DIGIT) begin
                        // Frame wrap: the new snapshot is taken in the same
                        // clk as the entry into BLANK.
                        digit_nxt = '0;
                        snap      = 1'b1;
                     end else begin
                        digit_nxt = digit + 1'b1;
                     end
                  end else begin
                     dwell_nxt = dwell + 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign shadow_value_nxt = snap ? i_value : shadow_value;
   assign shadow_dp_nxt    = snap ? i_dp    : shadow_dp;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   // keep[k] is set when some nibble at index >= k is non-zero. Digit 0 is
   // always kept. This mask is taken from the shadow, so it changes only at
   // frame boundaries.
   always_comb begin
      logic seen;
      seen = 1'b0;
      keep = '0;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         seen    = seen | (shadow_value_nxt[4*k +: 4] != 4'h0);
         keep[k] = seen;
      end
      keep[0] = 1'b1;
   end
`else
   assign keep = '1;
`endif

   // -------------------------------------------------------------------------
   // Output logic (registered above)
   // -------------------------------------------------------------------------
   always_comb begin
      nibble         = shadow_value_nxt[{digit_nxt, 2'b00} +: 4];
      seg_hi         = keep[digit_nxt] ? decode(nibble) : 7'b0000000;
      an_hot         = '0;
      an_hot[digit_nxt] = 1'b1;
      seg_nxt        = SEG_OFF;
      dp_nxt         = SEG_INV;
      an_nxt         = AN_OFF;
      if (state_nxt == SHOW) begin
         seg_nxt = seg_hi ^ SEG_OFF;
         dp_nxt  = shadow_dp_nxt[digit_nxt] ^ SEG_INV;
         an_nxt  = an_hot ^ AN_OFF;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// Testbench for seven_seg_scanner, using the default active-low 4-digit build.
// Instance dut uses DWELL=1. Instance dut3 uses DWELL=3 and shares all inputs
// with dut; it is checked only during the dwell sequence.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_tick = 1'b0;
   logic        i_en = 1'b0;
   logic [15:0] i_value = '0;
   logic [3:0]  i_dp = '0;

   logic [6:0]  o_seg,  o_seg3;
   logic        o_dp,   o_dp3;
   logic [3:0]  o_an,   o_an3;
   logic        o_frame, o_frame3;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   seven_seg_scanner #(.N_DIGITS(4), .DWELL(1)) dut (
      .clk(clk), .rst(rst), .i_tick(i_tick), .i_en(i_en),
      .i_value(i_value), .i_dp(i_dp),
      .o_seg(o_seg), .o_dp(o_dp), .o_an(o_an), .o_frame(o_frame)
   );

   seven_seg_scanner #(.N_DIGITS(4), .DWELL(3)) dut3 (
      .clk(clk), .rst(rst), .i_tick(i_tick), .i_en(i_en),
      .i_value(i_value), .i_dp(i_dp),
      .o_seg(o_seg3), .o_dp(o_dp3), .o_an(o_an3), .o_frame(o_frame3)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Active-low expected segment pattern, written out from the decode table.
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'hA: s = 7'b0001000;
         4'hF: s = 7'b0001110;
         default: s = 7'bxxxxxxx;
      endcase
      return s;
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   // Called at a negedge. Raises i_tick for one clk and returns at the next
   // negedge, when outputs reflect the BLANK clk.
   task automatic adv_edge();
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
   endtask

   task automatic show(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
      check({tag, "_an"}, 32'(o_an), 32'(an));
      check({tag, "_seg"}, 32'(o_seg), 32'(seg));
      check({tag, "_dp"}, 32'(o_dp), 32'(dp));
      check({tag, "_frame"}, 32'(o_frame), 32'd0);
   endtask

   task automatic blank(input string tag, input logic frame);
      check({tag, "_an"}, 32'(o_an), 32'hF);
      check({tag, "_seg"}, 32'(o_seg), 32'(SEG_BLANK));
      check({tag, "_frame"}, 32'(o_frame), 32'(frame));
   endtask

   initial begin
      logic [3:0] an_e;
      int d;

      // reset state
      cyc();
      blank("reset", 1'b0);
      check("reset_dp", 32'(o_dp), 32'd1);

      // basic scan of 12AF
      rst = 1'b0; i_en = 1'b1; i_value = 16'h12AF; i_dp = 4'b0010;
      cyc(); cyc();
      blank("idle", 1'b0);
      adv_edge(); blank("blank0", 1'b1);
      cyc();      show("d0_F", 4'b1110, seg_of(4'hF), 1'b1);
      adv_edge(); blank("blank1", 1'b0);
      cyc();      show("d1_A", 4'b1101, seg_of(4'hA), 1'b0);
      i_value = 16'h0000;   // not visible until the next snapshot
      adv_edge(); cyc(); show("d2_2", 4'b1011, seg_of(4'h2), 1'b1);
      adv_edge(); cyc(); show("d3_1", 4'b0111, seg_of(4'h1), 1'b1);
      adv_edge(); blank("wrap", 1'b1);
      cyc();      show("z0", 4'b1110, seg_of(4'h0), 1'b1);
      adv_edge(); cyc(); show("z1", 4'b1101, LZB ? SEG_BLANK : seg_of(4'h0), 1'b0);

      // drop i_en together with adv while showing
      i_en = 1'b0; i_tick = 1'b1;
      cyc();
      blank("en_drop", 1'b0);
      check("en_drop_dp", 32'(o_dp), 32'd1);
      i_tick = 1'b0;
      cyc();
      i_en = 1'b1;
      cyc(); cyc();
      blank("reen_idle", 1'b0);
      adv_edge(); blank("reen_blank", 1'b1);
      cyc();      show("reen_d0", 4'b1110, seg_of(4'h0), 1'b1);

      // asynchronous reset mid-frame
      #1 rst = 1'b1;
      #1 blank("async_rst", 1'b0);
      check("async_rst_dp", 32'(o_dp), 32'd1);
      @(negedge clk); rst = 1'b0;
      cyc(); cyc();
      blank("post_rst_idle", 1'b0);
      adv_edge(); blank("post_rst_blank", 1'b1);
      cyc();      show("post_rst_d0", 4'b1110, seg_of(4'h0), 1'b1);

      // DWELL=3 sequence on dut3, with a tick period of 4 clks
      i_en = 1'b0; i_value = 16'h3210; i_dp = 4'b0000;
      cyc();
      i_en = 1'b1;
      cyc();
      for (int i = 0; i <= 48; i++) begin
         i_tick = ((i % 4) < 2);
         @(negedge clk);
         d = (i / 12) % 4;
         an_e = ~(4'b0001 << d);
         if ((i % 12) == 0) begin
            check($sformatf("dw_an_%0d", i), 32'(o_an3), 32'hF);
            check($sformatf("dw_seg_%0d", i), 32'(o_seg3), 32'(SEG_BLANK));
         end else begin
            check($sformatf("dw_an_%0d", i), 32'(o_an3), 32'(an_e));
            check($sformatf("dw_seg_%0d", i), 32'(o_seg3), 32'(seg_of(4'(d))));
         end
         check($sformatf("dw_frame_%0d", i), 32'(o_frame3), 32'((i % 48) == 0));
      end
      i_tick = 1'b0;
      cyc(); cyc();

      // leading zeros: 0042, then 0000
      i_en = 1'b0; i_value = 16'h0042;
      cyc();
      i_en = 1'b1;
      adv_edge(); blank("lz_blank", 1'b1);
      cyc();      show("lz_d0", 4'b1110, seg_of(4'h2), 1'b1);
      adv_edge(); cyc(); show("lz_d1", 4'b1101, seg_of(4'h4), 1'b1);
      adv_edge(); cyc(); show("lz_d2", 4'b1011, LZB ? SEG_BLANK : seg_of(4'h0), 1'b1);
      adv_edge(); cyc(); show("lz_d3", 4'b0111, LZB ? SEG_BLANK : seg_of(4'h0), 1'b1);
      i_en = 1'b0; i_value = 16'h0000;
      cyc();
      i_en = 1'b1;
      adv_edge(); cyc(); show("lz0_d0", 4'b1110, seg_of(4'h0), 1'b1);
      adv_edge(); cyc(); show("lz0_d1", 4'b1101, LZB ? SEG_BLANK : seg_of(4'h0), 1'b1);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Multiplexed 7-segment display driver; sits directly downstream of the frequency divider.
- Consumes the divider's slow square-wave output as a scan tick and time-multiplexes N_DIGITS hex digits onto one shared segment bus plus per-digit anode enables.
- Provides tear-free frame updates, inter-digit blanking against ghosting, and a frame-boundary pulse for upstream value refresh.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- DWELL, 1, scan-tick rising edges spent on each digit (>=1).
- SEG_ACTIVE_LOW, 1, 1 = o_seg/o_dp driven low to light a segment.
- AN_ACTIVE_LOW, 1, 1 = o_an bit driven low to enable a digit.

Ports:
- clk  in  1  system clock (same domain as the divider).
- rst  in  1  asynchronous reset, active-high.
- i_tick  in  1  divided clock from the frequency divider; registered in clk domain, used only as a level.
- i_en  in  1  display enable.
- i_value  in  4*N_DIGITS  hex nibbles; digit k = i_value[4k+3:4k]; digit 0 rightmost.
- i_dp  in  N_DIGITS  decimal-point request per digit.
- o_seg  out  7  segments {g,f,e,d,c,b,a}; bit0 = a.
- o_dp  out  1  decimal point of the active digit.
- o_an  out  N_DIGITS  one-hot digit enable.
- o_frame  out  1  one-clk pulse when a new frame snapshot is taken.

Behaviour:
- All outputs registered.
- Reset:
  - State IDLE; digit index 0; dwell count 0; tick_d 0; shadow value/dp 0.
  - o_an, o_seg, o_dp all inactive (every segment off, no digit enabled); o_frame 0.
- Tick edge: adv = i_tick & ~tick_d; tick_d <= i_tick every clk. adv is asserted for exactly one clk per i_tick period.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - Outputs inactive.
  - On adv with i_en=1: load shadow from i_value/i_dp, digit=0, dwell=0, pulse o_frame, go to BLANK.
- BLANK:
  - o_an all inactive for exactly one clk; o_seg off.
  - Next clk: go to SHOW.
- SHOW:
  - o_an one-hot at digit index; o_seg = decode(shadow nibble); o_dp = shadow dp bit.
  - On adv, dwell increments. When dwell == DWELL-1 and adv: dwell=0, digit index increments, go to BLANK.
  - Digit wrap N_DIGITS-1 -> 0: reload shadow and pulse o_frame in the same clk as the BLANK entry.
- Latency: new digit's anode asserted on the 2nd clk edge after the first clk at which adv=1 (edge 1 = BLANK, edge 2 = SHOW).
- i_en=0 in any state: next clk go to IDLE, outputs inactive, digit=0, dwell=0. i_en takes priority over adv in the same cycle.
- i_value/i_dp changes mid-frame have no visible effect until the next snapshot.
- Decode, active-high form (inverted when SEG_ACTIVE_LOW=1):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Reset asserted mid-scan: outputs inactive immediately (async), state IDLE. After release, scanning restarts only on the next adv with i_en=1.
- Digit index width = clog2(N_DIGITS); must never exceed N_DIGITS-1.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant non-zero nibble of the shadow value show segments off. Anode still scans; dp still follows shadow. Digit 0 is always shown (value 0 displays a single "0"). Evaluated on the shadow only, so blanking changes only at frame boundaries.
- Undefined: every digit decoded, leading zeros shown.

Test Plan:
- Reset, then i_en=1, i_value=16'h12AF, DWELL=1, toggling i_tick -> first adv gives o_frame pulse, one BLANK clk, then o_an=4'b1110 with o_seg=7'b0001110 (F, active-low). Successive adv edges give digits A, 2, 1 on o_an=1101, 1011, 0111, then wrap with a new o_frame.
- Change i_value to 16'h0000 while digit 1 is shown -> digits 2 and 3 still show 2 and 1; 0 appears on all digits only after the next o_frame.
- DWELL=3 -> each anode held for exactly 3 i_tick periods; exactly one all-off clk between consecutive digits; never two anode bits active.
- Drop i_en mid-SHOW together with adv -> next clk o_an=4'b1111 and o_seg=7'b1111111; re-enable -> scan restarts at digit 0 with o_frame.
- Assert rst mid-frame -> outputs inactive without waiting for a clk edge; after release, no anode until the first adv with i_en=1.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN defined, i_value=16'h0042 -> digits 3 and 2 segments off, digits 1 and 0 show 4 and 2. i_value=16'h0000 -> only digit 0 shows "0".
